dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  Load/store initiator between the CPU memory stage and the word-only data memory.
//  Accepts byte/half/word load/store requests and drives the memory's combinational-read,
//  posedge-write port. Sub-word stores are done as read-modify-write.
//  Returns sign/zero-extended load data and flags misaligned accesses.
// PARAMETERS
//  ADDR_W  32  address width (= `ADDR_SIZE)
//  DATA_W  32  data width (= `WORD_LEN); only 32 is supported
// PORTS
//  clk         in   1       single clock; all state updates on posedge
//  rstn        in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit idle, request accepted when valid&ready
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word (11 is treated as word)
//  req_unsigned in  1       load zero-extend (LBU/LHU); ignored for stores
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, right-justified
//  resp_valid  out  1       completion; held until resp_ready
//  resp_ready  in   1       consumer takes response
//  resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
//  resp_err    out  1       misaligned access; no memory access performed
//  mem_addr    out  ADDR_W  word address to memory, {addr_q[31:2],2'b00}; 0 when idle
//  mem_we      out  1       memory write enable
//  mem_wdata   out  DATA_W  full word to write
//  mem_rdata   in   DATA_W  combinational read data for mem_addr
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE, req_ready=1, resp_valid=0, resp_err=0,
//   resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. A write in flight is dropped.
//   No mem_we pulse occurs while or after reset is asserted until a new request arrives.
//  FSM: IDLE -> ACCESS -> [WRITE] -> RESP -> IDLE.
//  IDLE: req_ready=1. On valid&ready, register we/size/unsigned/addr/wdata.
//   Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1.
//  ACCESS (T+1): mem_addr driven from the registered address.
//   load: extract byte/half at addr[1:0] from mem_rdata, extend, latch -> RESP.
//   word store: mem_we=1, mem_wdata=wdata -> RESP.
//   sub-word store: merge wdata lane(s) into mem_rdata, latch merged word -> WRITE.
//  WRITE (T+2): mem_we=1, mem_wdata=merged word -> RESP.
//  RESP: resp_valid=1. IDLE on resp_ready. req_ready=0 in every state except IDLE.
//  Latency from accept to resp_valid:
//   misaligned 1 cycle; load or word store 2 cycles; byte/half store 3 cycles.
//  Lane rules: byte lane = addr[1:0]; half lane = addr[1]. Load sign bit is the lane MSB.
//  mem_we is high for exactly one cycle per store and never for loads or errors.
//  Back-to-back requests: earliest next accept is the cycle after resp accept.
// CONFIGURATION
//  `DMEM_TRACE_EN defined: on each mem_we cycle the unit prints
//   $display("dataaddr = %h, memdata = %h", mem_addr, mem_wdata).
//  Not defined: no display statements. Cycle behaviour is identical either way.
// STRUCTURE
//  defines.v: `ADDR_SIZE, `WORD_LEN, size codes `MEM_SZ_B/H/W, and FSM state encodings.
//  Sub-module lsu_align (combinational) does load extract/extend and store lane merge.
//   Its outputs are the misaligned flag, the load value and the merged word.
// TESTING
//  1 LW 0x10, mem word=0xDEADBEEF -> resp at T+2, rdata=0xDEADBEEF, err=0, mem_we never 1.
//  2 LB 0x13 / LBU 0x13 on 0x80FF_FF7F -> rdata=0xFFFFFF80 / 0x00000080.
//  3 SB 0x22, wdata=0xAB, word 0x11223344 -> T+2 mem_we=1, mem_wdata=0x11AB3344, resp T+3.
//  4 SH 0x1 -> err=1 at T+1, rdata=0, no mem_we; SW 0x6 -> same.
//  5 resp_ready held 0 for 3 cycles -> resp_valid and data stable, req_ready=0 throughout.
//  6 rstn low during WRITE of a SH -> mem_we=0 immediately, state IDLE, memory unchanged.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// ============================================================================
// Module : dmem_access_unit_pkg
// Shared widths, access-size codes and FSM states for the data-memory access unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_access_unit_pkg;

   localparam int ADDR_SIZE = 32;
   localparam int WORD_LEN  = 32;

   localparam logic [1:0] MEM_SZ_B = 2'b00;
   localparam logic [1:0] MEM_SZ_H = 2'b01;
   localparam logic [1:0] MEM_SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WRITE  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_access_unit_align.sv
// ============================================================================
// Module : lsu_align
// Combinational lane logic: misalignment check, load extract/extend, store merge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
   import dmem_access_unit_pkg::*;
(
   input  logic [1:0]          i_size,
   input  logic [1:0]          i_lane,
   input  logic                i_unsigned,
   input  logic [WORD_LEN-1:0] i_wdata,
   input  logic [WORD_LEN-1:0] i_rdata,
   output logic                o_misaligned,
   output logic [WORD_LEN-1:0] o_load,
   output logic [WORD_LEN-1:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Size code 11 behaves as a word everywhere, so bit 1 alone marks a word.
   assign o_misaligned = ((i_size == MEM_SZ_H) && i_lane[0]) ||
                         (i_size[1] && (i_lane != 2'b00));

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_lane)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_load = i_rdata;
      case (i_size)
         MEM_SZ_B: o_load = i_unsigned ? {24'h000000, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
         MEM_SZ_H: o_load = i_unsigned ? {16'h0000, w_half}
                                       : {{16{w_half[15]}}, w_half};
         default:  o_load = i_rdata;
      endcase
   end

   always_comb begin
      o_merged = i_rdata;
      case (i_size)
         MEM_SZ_B: begin
            case (i_lane)
               2'd0: o_merged[7:0]   = i_wdata[7:0];
               2'd1: o_merged[15:8]  = i_wdata[7:0];
               2'd2: o_merged[23:16] = i_wdata[7:0];
               2'd3: o_merged[31:24] = i_wdata[7:0];
               default: o_merged = i_rdata;
            endcase
         end
         MEM_SZ_H: begin
            if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
            else           o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module : dmem_access_unit
// Byte/half/word load-store initiator for a word-only memory; sub-word stores
// use read-modify-write. Define DMEM_TRACE_EN to print every memory write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int ADDR_W = ADDR_SIZE,
   parameter int DATA_W = WORD_LEN
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_merged;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_idle;
   logic [1:0]        w_size_sel;
   logic [1:0]        w_lane_sel;
   logic              w_misaligned;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_merged;
   logic [ADDR_W-1:0] w_word_addr;

   // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_size_sel  = w_idle ? req_size       : r_size;
   assign w_lane_sel  = w_idle ? req_addr[1:0]  : r_addr[1:0];
   assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

   lsu_align u_align (
      .i_size       (w_size_sel),
      .i_lane       (w_lane_sel),
      .i_unsigned   (r_unsigned),
      .i_wdata      (r_wdata),
      .i_rdata      (mem_rdata),
      .o_misaligned (w_misaligned),
      .o_load       (w_load_val),
      .o_merged     (w_merged)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_misaligned ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            mem_addr = w_word_addr;
            if (r_we && r_size[1]) begin
               mem_we    = 1'b1;
               mem_wdata = r_wdata;
               w_next    = ST_RESP;
            end else if (r_we) begin
               w_next = ST_WRITE;
            end else begin
               w_next = ST_RESP;
            end
         end
         ST_WRITE: begin
            mem_addr  = w_word_addr;
            mem_we    = 1'b1;
            mem_wdata = r_merged;
            w_next    = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we       <= 1'b0;
         r_size     <= MEM_SZ_W;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_merged   <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_err      <= w_misaligned;
                  r_rdata    <= '0;
               end
            end
            ST_ACCESS: begin
               if (!r_we) r_rdata <= w_load_val;
               r_merged <= w_merged;
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = resp_valid ? r_rdata : '0;
   assign resp_err   = resp_valid & r_err;

`ifdef DMEM_TRACE_EN
   always @(posedge clk) begin
      if (mem_we) $display("dataaddr = %h, memdata = %h", mem_addr, mem_wdata);
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// Module : tb_dmem_access_unit
// Scoreboard bench for dmem_access_unit against a behavioural word memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_unit;
   import dmem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] tb_mem  [0:15];
   logic [31:0] ref_mem [0:15];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nwe;
      logic [31:0] wword;
   } exp_t;
   exp_t sb[$];

   int tests_run = 0;
   int failed    = 0;

   always #5 clk = ~clk;

   dmem_access_unit dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = tb_mem[mem_addr[5:2]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;

   function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b01) return a[0];
      if (sz[1])       return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic u, input logic [31:0] a);
      logic [31:0] s;
      if (sz == 2'b00) begin
         s = w >> (8 * a[1:0]);
         return u ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]};
      end else if (sz == 2'b01) begin
         s = w >> (16 * a[1]);
         return u ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
      end
      return w;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] d);
      logic [31:0] m;
      if (sz == 2'b00) begin
         m = 32'hFF << (8 * a[1:0]);
         return (w & ~m) | ((d & 32'hFF) << (8 * a[1:0]));
      end else if (sz == 2'b01) begin
         m = 32'hFFFF << (16 * a[1]);
         return (w & ~m) | ((d & 32'hFFFF) << (16 * a[1]));
      end
      return d;
   endfunction

   task automatic set_word(input int idx, input logic [31:0] v);
      tb_mem[idx]  = v;
      ref_mem[idx] = v;
   endtask

   // Issue one request, track latency and write pulses, then compare the response.
   task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input int hold);
      exp_t e, g;
      int idx, cyc, nwe;
      logic got;
      logic [31:0] held;
      idx    = int'(a[5:2]);
      e.err  = is_mis(sz, a);
      e.nwe  = (!e.err && we) ? 1 : 0;
      e.lat  = e.err ? 1 : ((we && !sz[1]) ? 3 : 2);
      e.rdata = (e.err || we) ? 32'h0 : model_load(ref_mem[idx], sz, u, a);
      e.wword = model_store(ref_mem[idx], sz, a, d);
      if (e.nwe == 1) ref_mem[idx] = e.wword;
      sb.push_back(e);

      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b1) begin
         failed++;
         $display("FAIL %s req_ready_idle: got %b expected 1", nm, req_ready);
      end
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;

      cyc = 0; nwe = 0; got = 1'b0;
      while (cyc < 10 && !got) begin
         @(negedge clk);
         cyc++;
         if (mem_we === 1'b1) begin
            nwe++;
            if (e.nwe == 1) begin
               tests_run++;
               if (mem_wdata !== e.wword) begin
                  failed++;
                  $display("FAIL %s mem_wdata: got %h expected %h", nm, mem_wdata, e.wword);
               end
            end
         end
         if (resp_valid === 1'b1) got = 1'b1;
      end

      g = sb.pop_front();
      tests_run++;
      if (!got) begin
         failed++;
         $display("FAIL %s timeout: got no resp_valid expected resp within %0d cycles", nm, g.lat);
      end else begin
         if (cyc != g.lat) begin
            failed++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc, g.lat);
         end
         tests_run++;
         if (resp_rdata !== g.rdata || resp_err !== g.err) begin
            failed++;
            $display("FAIL %s resp: got %h/%b expected %h/%b", nm, resp_rdata, resp_err,
                     g.rdata, g.err);
         end
         tests_run++;
         if (nwe != g.nwe || req_ready !== 1'b0) begin
            failed++;
            $display("FAIL %s we_count/ready: got %0d/%b expected %0d/0", nm, nwe, req_ready,
                     g.nwe);
         end
         held = resp_rdata;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
               failed++;
               $display("FAIL %s hold%0d: got v=%b d=%h r=%b expected v=1 d=%h r=0", nm, h,
                        resp_valid, resp_rdata, req_ready, held);
            end
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1 resp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
         failed++;
         $display("FAIL reset_ctrl: got rdy=%b v=%b e=%b expected 1/0/0", req_ready,
                  resp_valid, resp_err);
      end
      tests_run++;
      if (resp_rdata !== 32'h0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
          mem_wdata !== 32'h0) begin
         failed++;
         $display("FAIL reset_data: got rd=%h we=%b a=%h wd=%h expected zeros", resp_rdata,
                  mem_we, mem_addr, mem_wdata);
      end
      rstn = 1'b1;
   endtask

   task automatic test_load_word();
      set_word(4, 32'hDEADBEEF);
      issue("lw_0x10", 1'b0, MEM_SZ_W, 1'b0, 32'h10, 32'h0, 0);
   endtask

   task automatic test_load_sub();
      set_word(4, 32'h80FFFF7F);
      issue("lb_0x13", 1'b0, MEM_SZ_B, 1'b0, 32'h13, 32'h0, 0);
      issue("lbu_0x13", 1'b0, MEM_SZ_B, 1'b1, 32'h13, 32'h0, 0);
      issue("lb_0x10", 1'b0, MEM_SZ_B, 1'b0, 32'h10, 32'h0, 0);
      issue("lh_0x12", 1'b0, MEM_SZ_H, 1'b0, 32'h12, 32'h0, 0);
      issue("lhu_0x12", 1'b0, MEM_SZ_H, 1'b1, 32'h12, 32'h0, 0);
   endtask

   task automatic test_store_sub();
      set_word(8, 32'h11223344);
      issue("sb_0x22", 1'b1, MEM_SZ_B, 1'b0, 32'h22, 32'h000000AB, 0);
      issue("sh_0x20", 1'b1, MEM_SZ_H, 1'b0, 32'h20, 32'hFFFF5A5A, 0);
      issue("sw_0x24", 1'b1, MEM_SZ_W, 1'b0, 32'h24, 32'hCAFEF00D, 0);
      issue("lw_0x20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0);
   endtask

   task automatic test_misaligned();
      issue("sh_0x1", 1'b1, MEM_SZ_H, 1'b0, 32'h1, 32'h1234, 0);
      issue("sw_0x6", 1'b1, MEM_SZ_W, 1'b0, 32'h6, 32'h5678, 0);
      issue("lh_0x13", 1'b0, MEM_SZ_H, 1'b0, 32'h13, 32'h0, 0);
   endtask

   task automatic test_backpressure();
      issue("lw_hold", 1'b0, MEM_SZ_W, 1'b0, 32'h10, 32'h0, 3);
   endtask

   task automatic test_reset_in_write();
      set_word(2, 32'h55667788);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = MEM_SZ_H; req_unsigned = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h1234;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (mem_we !== 1'b1) begin
         failed++;
         $display("FAIL rst_write_pre: got mem_we=%b expected 1", mem_we);
      end
      #1 rstn = 1'b0;
      #1;
      tests_run++;
      if (mem_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failed++;
         $display("FAIL rst_write_now: got we=%b rdy=%b v=%b expected 0/1/0", mem_we,
                  req_ready, resp_valid);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      tests_run++;
      if (tb_mem[2] !== 32'h55667788 || mem_we !== 1'b0) begin
         failed++;
         $display("FAIL rst_write_mem: got %h we=%b expected 55667788 we=0", tb_mem[2], mem_we);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 63));
         issue($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), sz,
               1'($urandom_range(0, 1)), a, $urandom, 0);
      end
      tests_run++;
      for (int k = 0; k < 16; k++) begin
         if (tb_mem[k] !== ref_mem[k]) begin
            failed++;
            $display("FAIL mem_final[%0d]: got %h expected %h", k, tb_mem[k], ref_mem[k]);
            break;
         end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; rstn = 1'b0;
      for (int k = 0; k < 16; k++) set_word(k, 32'h01010101 * k + 32'h00C0FFEE);
      test_reset();
      test_load_word();
      test_load_sub();
      test_store_sub();
      test_misaligned();
      test_backpressure();
      test_reset_in_write();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
